// File: rtl/mem_byte_arb.sv
`default_nettype none
// ============================================================================
// Module      : mem_byte_arb
// Description : Byte-serial RAM port shared by the fetch and load/store units,
//               with fair arbitration and I/O store throttling.
// Revision    : 1.0
// ============================================================================
module mem_byte_arb #(
  parameter logic [1:0] IO_SEL = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_done,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic [31:0] ls_rdata,
  output logic        ls_done,
  input  logic        flush
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_WRITE  = 3'd2,
    S_IOWAIT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic        r_last_ls;
  logic        r_first;
  logic        r_fin;
  logic        r_is_ls;
  logic        r_io;
  logic [2:0]  r_n;
  logic [31:0] r_base;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;
  logic [31:0] r_if_data;
  logic [31:0] r_ls_rdata;
  logic        r_if_done;
  logic        r_ls_done;
  logic [31:0] r_mem_a;
  logic [7:0]  r_mem_dout;
  logic        r_mem_wr;

  logic [2:0]  w_ls_n;
  logic        w_ls_io;
  logic        w_if_v;
  logic        w_take_ls;
  logic        w_take_if;
  logic        w_last;
  logic [2:0]  w_nidx;
  logic        w_nidx_ok;
  logic [31:0] w_rd_addr;
  logic [1:0]  w_cnt_inc;
  logic [31:0] w_wr_addr_cur;
  logic [31:0] w_wr_addr_nxt;
  logic [31:0] w_buf_next;

  function automatic logic [7:0] sel_byte(input logic [31:0] d, input logic [1:0] i);
    case (i)
      2'd0:    sel_byte = d[7:0];
      2'd1:    sel_byte = d[15:8];
      2'd2:    sel_byte = d[23:16];
      default: sel_byte = d[31:24];
    endcase
  endfunction

  always_comb begin
    case (ls_size)
      2'b00:   w_ls_n = 3'd1;
      2'b01:   w_ls_n = 3'd2;
      default: w_ls_n = 3'd4;
    endcase
  end

  assign w_ls_io   = (ls_addr[17:16] == IO_SEL);
  assign w_if_v    = if_req & ~flush;
  // On contention the LSU wins unless it had the previous grant.
  assign w_take_ls = ls_req & (~w_if_v | ~r_last_ls);
  assign w_take_if = w_if_v & ~w_take_ls;

  assign w_last        = ({1'b0, r_cnt} == (r_n - 3'd1));
  assign w_nidx        = r_first ? 3'd1 : ({1'b0, r_cnt} + 3'd2);
  assign w_nidx_ok     = (w_nidx < r_n);
  assign w_rd_addr     = r_base + {29'd0, w_nidx};
  assign w_cnt_inc     = r_cnt + 2'd1;
  assign w_wr_addr_cur = r_base + {30'd0, r_cnt};
  assign w_wr_addr_nxt = r_base + {30'd0, w_cnt_inc};

  always_comb begin
    w_buf_next = r_buf;
    w_buf_next[{r_cnt, 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 2'd0;
      r_last_ls  <= 1'b0;
      r_first    <= 1'b0;
      r_fin      <= 1'b0;
      r_is_ls    <= 1'b0;
      r_io       <= 1'b0;
      r_n        <= 3'd0;
      r_base     <= 32'd0;
      r_wdata    <= 32'd0;
      r_buf      <= 32'd0;
      r_if_data  <= 32'd0;
      r_ls_rdata <= 32'd0;
      r_if_done  <= 1'b0;
      r_ls_done  <= 1'b0;
      r_mem_a    <= 32'd0;
      r_mem_dout <= 8'd0;
      r_mem_wr   <= 1'b0;
    end else if (rdy) begin
      case (r_state)
        S_IDLE: begin
          r_cnt   <= 2'd0;
          r_first <= 1'b1;
          r_fin   <= 1'b0;
          r_buf   <= 32'd0;
          if (w_take_ls) begin
            r_is_ls   <= 1'b1;
            r_last_ls <= 1'b1;
            r_base    <= ls_addr;
            r_wdata   <= ls_wdata;
            r_n       <= w_ls_n;
            r_io      <= w_ls_io;
            if (!ls_we) begin
              r_state <= S_READ;
              r_mem_a <= ls_addr;
            end else if (w_ls_io && io_buffer_full) begin
              r_state <= S_IOWAIT;
            end else begin
              r_state    <= S_WRITE;
              r_mem_a    <= ls_addr;
              r_mem_dout <= ls_wdata[7:0];
              r_mem_wr   <= 1'b1;
            end
          end else if (w_take_if) begin
            r_is_ls   <= 1'b0;
            r_last_ls <= 1'b0;
            r_base    <= if_addr;
            r_n       <= 3'd4;
            r_io      <= 1'b0;
            r_state   <= S_READ;
            r_mem_a   <= if_addr;
          end
        end

        S_READ: begin
          if (flush && !r_is_ls) begin
            r_state <= S_IDLE;
            r_mem_a <= 32'd0;
          end else if (r_first) begin
            r_first <= 1'b0;
            r_mem_a <= w_nidx_ok ? w_rd_addr : 32'd0;
          end else begin
            // mem_din carries the byte addressed one cycle earlier (lane r_cnt).
            r_buf <= w_buf_next;
            if (w_last) begin
              r_state <= S_DONE;
              r_mem_a <= 32'd0;
              if (r_is_ls) begin
                r_ls_rdata <= w_buf_next;
                r_ls_done  <= 1'b1;
              end else begin
                r_if_data <= w_buf_next;
                r_if_done <= 1'b1;
              end
            end else begin
              r_cnt   <= w_cnt_inc;
              r_mem_a <= w_nidx_ok ? w_rd_addr : 32'd0;
            end
          end
        end

        S_WRITE: begin
          if (r_io) begin
            // The buffer-full flag lags the write, so always wait one cycle.
            r_state    <= S_IOWAIT;
            r_fin      <= w_last;
            r_mem_a    <= 32'd0;
            r_mem_dout <= 8'd0;
            r_mem_wr   <= 1'b0;
            if (!w_last) r_cnt <= w_cnt_inc;
          end else if (w_last) begin
            r_state    <= S_DONE;
            r_ls_done  <= 1'b1;
            r_mem_a    <= 32'd0;
            r_mem_dout <= 8'd0;
            r_mem_wr   <= 1'b0;
          end else begin
            r_cnt      <= w_cnt_inc;
            r_mem_a    <= w_wr_addr_nxt;
            r_mem_dout <= sel_byte(r_wdata, w_cnt_inc);
          end
        end

        S_IOWAIT: begin
          if (r_fin) begin
            r_state   <= S_DONE;
            r_ls_done <= 1'b1;
          end else if (!io_buffer_full) begin
            r_state    <= S_WRITE;
            r_mem_a    <= w_wr_addr_cur;
            r_mem_dout <= sel_byte(r_wdata, r_cnt);
            r_mem_wr   <= 1'b1;
          end
        end

        S_DONE: begin
          r_state   <= S_IDLE;
          r_if_done <= 1'b0;
          r_ls_done <= 1'b0;
        end

        default: begin
          r_state    <= S_IDLE;
          r_mem_a    <= 32'd0;
          r_mem_dout <= 8'd0;
          r_mem_wr   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_a    = r_mem_a;
  assign mem_dout = r_mem_dout;
  assign mem_wr   = r_mem_wr;
  assign if_data  = r_if_data;
  assign if_done  = r_if_done;
  assign ls_rdata = r_ls_rdata;
  assign ls_done  = r_ls_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_byte_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_byte_arb
// Description : Scoreboard bench for mem_byte_arb with a registered RAM model.
// Revision    : 1.0
// ============================================================================
module tb_mem_byte_arb;

  logic        clk = 1'b0;
  logic        rst, rdy, io_buffer_full, flush;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic [1:0]  ls_size;
  logic [31:0] if_data, ls_rdata;
  logic        if_done, ls_done;

  int n_chk = 0;
  int n_err = 0;
  bit fresh = 1'b0;
  logic [31:0] m_last_load = 32'd0;
  logic [31:0] mon_e;
  logic [39:0] mon_w;
  logic [31:0] if_q[$];
  logic [31:0] ls_q[$];
  logic [39:0] wr_q[$];
  int lat;

  mem_byte_arb #(.IO_SEL(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_done(ls_done), .flush(flush)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h100: ram_byte = 8'h13;
      32'h101: ram_byte = 8'h05;
      32'h102: ram_byte = 8'h00;
      32'h103: ram_byte = 8'h00;
      default: ram_byte = a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = 32'd0;
    for (int i = 0; i < n; i++) w[i*8 +: 8] = ram_byte(a + i);
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // RAM answers one cycle after the address and stalls with rdy.
  always @(posedge clk) if (rdy) mem_din <= ram_byte(mem_a);
  always @(posedge clk) fresh = rdy && !rst;

  always @(negedge clk) begin
    if (fresh) begin
      if (if_done) begin
        if (if_q.size() == 0) check("if_extra", {31'd0, if_done}, 32'd0);
        else begin mon_e = if_q.pop_front(); check("if_data", if_data, mon_e); end
      end
      if (ls_done) begin
        if (ls_q.size() == 0) check("ls_extra", {31'd0, ls_done}, 32'd0);
        else begin mon_e = ls_q.pop_front(); check("ls_rdata", ls_rdata, mon_e); end
      end
      if (mem_wr) begin
        if (wr_q.size() == 0) check("wr_extra", {31'd0, mem_wr}, 32'd0);
        else begin
          mon_w = wr_q.pop_front();
          check("wr_addr", mem_a, mon_w[39:8]);
          check("wr_data", {24'd0, mem_dout}, {24'd0, mon_w[7:0]});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (if_done) if_req = 1'b0;
    if (ls_done) ls_req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((if_req || ls_req) && n < 60) begin step(); n++; end
    if (n >= 60) check("drain_timeout", {31'd0, if_req | ls_req}, 32'd0);
    step();
  endtask

  task automatic wait_ls(output int c);
    c = 0;
    do begin step(); c++; end while (!ls_done && c < 40);
  endtask

  task automatic push_load(input logic [31:0] a, input logic [1:0] sz);
    int n;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    m_last_load = exp_word(a, n);
    ls_q.push_back(m_last_load);
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = a; ls_size = sz;
  endtask

  task automatic push_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    int n;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    for (int i = 0; i < n; i++) wr_q.push_back({a + i, d[i*8 +: 8]});
    ls_q.push_back(m_last_load);
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = a; ls_size = sz; ls_wdata = d;
  endtask

  task automatic push_fetch(input logic [31:0] a);
    if_q.push_back(exp_word(a, 4));
    if_req = 1'b1; if_addr = a;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; flush = 1'b0;
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    if_addr = 32'd0; ls_addr = 32'd0; ls_wdata = 32'd0; ls_size = 2'b00;
    repeat (3) step();
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_dones", {30'd0, if_done, ls_done}, 32'd0);
    check("rst_if_data", if_data, 32'd0);
    check("rst_ls_rdata", ls_rdata, 32'd0);
    rst = 1'b0;
    step();

    // Fetch of 13 05 00 00 at 0x100.
    push_fetch(32'h100);
    step();
    for (int i = 0; i < 4; i++) begin
      check("f_addr", mem_a, 32'h100 + i);
      step();
    end
    check("f_early_done", {31'd0, if_done}, 32'd0);
    step();
    check("f_latency", {31'd0, if_done}, 32'd1);
    check("f_word", if_data, 32'h0000_0513);
    step();

    // Simultaneous requests: LSU first, then fetch wins against a new load.
    push_load(32'h2000, 2'b00);
    push_fetch(32'h300);
    step();
    check("arb_ls_first", mem_a, 32'h2000);
    lat = 0;
    while (ls_req && lat < 40) begin step(); lat++; end
    push_load(32'h2004, 2'b10);
    step();
    step();
    check("arb_if_second", mem_a, 32'h300);
    drain();

    // Half store crossing 0x1FFFF -> 0x20000.
    push_store(32'h1FFFF, 2'b01, 32'hABCD_1234);
    wait_ls(lat);
    check("sh_latency", lat, 32'd3);
    drain();

    // I/O byte store held off by a full buffer.
    io_buffer_full = 1'b1;
    push_store(32'h30000, 2'b00, 32'h0000_0041);
    step();
    check("io_wait0", {31'd0, mem_wr}, 32'd0);
    step();
    check("io_wait1", {31'd0, mem_wr}, 32'd0);
    step();
    io_buffer_full = 1'b0;
    check("io_wait2", {31'd0, mem_wr}, 32'd0);
    step();
    check("io_write", {31'd0, mem_wr}, 32'd1);
    step();
    io_buffer_full = 1'b1;
    check("io_post_wait", {30'd0, mem_wr, ls_done}, 32'd0);
    step();
    io_buffer_full = 1'b0;
    check("io_done", {31'd0, ls_done}, 32'd1);
    drain();

    // I/O half store: one wait cycle after every byte.
    push_store(32'h30010, 2'b01, 32'h0000_5A6B);
    wait_ls(lat);
    check("io_half_latency", lat, 32'd5);
    drain();

    // Flush on the second fetch address, pending load taken right after.
    if_req = 1'b1; if_addr = 32'h500;
    step();
    step();
    check("fl_addr1", mem_a, 32'h501);
    flush = 1'b1; if_req = 1'b0;
    push_load(32'h2010, 2'b00);
    step();
    flush = 1'b0;
    check("fl_bus_idle", mem_a, 32'd0);
    check("fl_no_done", {31'd0, if_done}, 32'd0);
    step();
    check("fl_ls_taken", mem_a, 32'h2010);
    drain();

    // Pause mid word load.
    push_load(32'h2020, 2'b10);
    step();
    step();
    check("rdy_a1", mem_a, 32'h2021);
    rdy = 1'b0;
    step();
    check("rdy_hold0", mem_a, 32'h2021);
    step();
    check("rdy_hold1", mem_a, 32'h2021);
    rdy = 1'b1;
    step();
    check("rdy_resume", mem_a, 32'h2022);
    drain();

    // Reset in the middle of a word store.
    wr_q.push_back({32'h2100, 8'hEF});
    wr_q.push_back({32'h2101, 8'hBE});
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h2100; ls_size = 2'b10; ls_wdata = 32'hDEAD_BEEF;
    step();
    step();
    rst = 1'b1; ls_req = 1'b0;
    step();
    check("rst_mid_bus", {mem_a[23:0], mem_dout}, 32'd0);
    check("rst_mid_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_mid_rdata", ls_rdata | if_data, 32'd0);
    rst = 1'b0;
    repeat (5) step();

    check("if_q_left", if_q.size(), 32'd0);
    check("ls_q_left", ls_q.size(), 32'd0);
    check("wr_q_left", wr_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_byte_arb.md
MEM_BYTE_ARB -- requirements
Module: mem_byte_arb

Interface
REQ-001 Parameter IO_SEL, default 2'b11: a byte address with addr[17:16]==IO_SEL is an I/O address.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 rdy  in  1  ready; low freezes all state and outputs.
REQ-005 mem_din  in  8  RAM read byte; valid the cycle after its address is driven.
REQ-006 mem_dout  out  8  RAM write byte.
REQ-007 mem_a  out  32  RAM byte address.
REQ-008 mem_wr  out  1  1 = write, 0 = read.
REQ-009 io_buffer_full  in  1  UART TX buffer full.
REQ-010 if_req  in  1  fetch read request; held until if_done.
REQ-011 if_addr  in  32  fetch word address.
REQ-012 if_data  out  32  fetched word, little-endian.
REQ-013 if_done  out  1  one-cycle pulse; if_data valid.
REQ-014 ls_req  in  1  load/store request; held until ls_done.
REQ-015 ls_we  in  1  1 = store.
REQ-016 ls_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-017 ls_addr  in  32  load/store byte address.
REQ-018 ls_wdata  in  32  store data; byte i = bits [8i+7:8i].
REQ-019 ls_rdata  out  32  load data, zero-extended, little-endian.
REQ-020 ls_done  out  1  one-cycle pulse; load data valid or store complete.
REQ-021 flush  in  1  mispredict; aborts the fetch transaction only.

Function
REQ-022 States: IDLE, READ, WRITE, IOWAIT, DONE; 2-bit byte counter; 1-bit last_ls fairness flag.
REQ-023 Requests are sampled only in IDLE; request fields are latched at the accepting edge.
- Arbitration: only one requester → that one; both requesting → LSU wins unless last_ls=1, in which case fetch wins.
- last_ls is set when an LSU transaction is accepted and cleared when a fetch is accepted.
REQ-024 N = 4 for fetch; N = 1/2/4 for LSU per ls_size; byte i uses address base+i (full 32-bit add, no alignment check).
REQ-025 READ: mem_wr=0; mem_a=base+i in the i-th cycle after acceptance (i=0..N-1).
- The byte is sampled from mem_din one cycle later into lane i; unused lanes are 0.
- DONE is entered at the edge after the last byte is sampled, so total acceptance-to-done = N+1 cycles.
REQ-026 WRITE: mem_wr=1, mem_a=base+i, mem_dout=byte i in cycle i; DONE follows the last byte.
REQ-027 I/O store: before each byte of a store to an I/O address, the block sits in IOWAIT while io_buffer_full=1, driving mem_wr=0 and mem_a=0.
- One mandatory IOWAIT cycle follows every I/O byte write, because io_buffer_full lags by one cycle.
REQ-028 I/O loads need no wait and follow REQ-025.
REQ-029 DONE lasts exactly one cycle: the matching done pulses, other requests are not sampled, and IDLE follows.
REQ-030 Requesters deassert req in the cycle after done; if req is still high in IDLE, it is a new request.
REQ-031 if_data and ls_rdata hold their last values until overwritten by the next completed transaction of the same port.
REQ-032 Bus outputs in IDLE and DONE: mem_a=0, mem_wr=0, mem_dout=0.
REQ-033 flush=1:
- During a fetch READ, the next state is IDLE, with no if_done and no if_data update.
- In IDLE, if_req is ignored that cycle.
- A fetch in DONE still pulses if_done.
- LSU transactions are unaffected.
REQ-034 rdy=0 holds the state, counter, latched fields and all outputs; the sequence resumes exactly where it stopped.

Reset
REQ-035 When rst=1 at an edge:
- State goes to IDLE, the counter and last_ls clear, and if_data, ls_rdata, if_done, ls_done, mem_a, mem_dout and mem_wr all go to 0.
- Any in-flight transaction is dropped, with no done pulse.
REQ-036 rst takes priority over rdy and flush.

Verification
REQ-037 Fetch: if_req, if_addr=0x100, RAM bytes 13 05 00 00 → mem_a 0x100..0x103 in consecutive cycles; if_done 5 cycles after acceptance; if_data=0x00000513.
REQ-038 Both requests: if_req and ls_req (load, byte, 0x2000) in the same cycle → load served first with ls_done; fetch served next.
- A repeated simultaneous pair after that → fetch wins (last_ls=1).
REQ-039 Store half: ls_wdata=0xABCD1234 to 0x1FFFF → mem_wr=1 at 0x1FFFF (dout 0x34), then at 0x20000 (0x12); ls_done the next cycle.
REQ-040 I/O store: byte 0x41 to 0x30000 with io_buffer_full=1 for 3 cycles → mem_wr stays 0 for those cycles, then one write of 0x41, one IOWAIT cycle, then ls_done.
REQ-041 Flush at the 2nd address of a fetch → no if_done, bus back to IDLE the next cycle, and a pending ls_req is accepted in the following IDLE cycle.
REQ-042 Pause and reset: rdy=0 for 2 cycles mid word load → mem_a held and the final data is correct; rst mid store → all outputs 0 next cycle and no ls_done.
